// File: rtl/kb_scan_decoder.sv
// rtl/kb_scan_decoder.sv - PS/2 set-2 scan byte decoder with event FIFO and shift tracking
module kb_scan_decoder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 50000,
  parameter int TW      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] kb_byte,
  input  logic       kb_avail,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_rel,
  output logic       shift_held,
  output logic       err_ovf,
  output logic       err_kb
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_E0   = 2'd1,
    S_F0   = 2'd2,
    S_E0F0 = 2'd3
  } state_t;

  // Synchroniser, edge detect and captured byte
  logic       avail_s1_q, avail_s2_q, avail_s3_q;
  logic       byte_vld_q;
  logic [7:0] byte_q;
  logic       avail_rise;

  // Prefix FSM and prefix timer
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  // Decode results for the byte being processed this cycle
  logic emit, emit_ext, emit_rel, kb_bad;
  logic is_e0, is_f0, is_bad, is_ack;

  // Shift tracking
  logic lshift_q, lshift_d, rshift_q, rshift_d, shift_held_q;

  // Event FIFO
  logic [9:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_full, do_push, do_pop, ovf;
  logic [9:0]    head;

  // Error pulses
  logic err_kb_q, err_ovf_q;

  assign avail_rise = avail_s2_q & ~avail_s3_q;

  // Bring kb_avail into the clk domain and latch the byte on its rising edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avail_s1_q <= 1'b0;
      avail_s2_q <= 1'b0;
      avail_s3_q <= 1'b0;
      byte_vld_q <= 1'b0;
      byte_q     <= 8'h00;
    end else begin
      avail_s1_q <= kb_avail;
      avail_s2_q <= avail_s1_q;
      avail_s3_q <= avail_s2_q;
      byte_vld_q <= avail_rise;
      if (avail_rise) begin
        byte_q <= kb_byte;
      end
    end
  end

  assign is_e0  = (byte_q == 8'hE0);
  assign is_f0  = (byte_q == 8'hF0);
  assign is_bad = (byte_q == 8'h00) || (byte_q == 8'hFF);
  assign is_ack = (byte_q == 8'hAA) || (byte_q == 8'hFA) || (byte_q == 8'hFE) ||
                  (byte_q == 8'hEE) || (byte_q == 8'hFC);

  // Prefix FSM state and timer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Prefix decode: next state, event emission and prefix timeout
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_rel = 1'b0;
    kb_bad   = 1'b0;
    if (byte_vld_q) begin
      timer_d = '0;
      case (state_q)
        S_IDLE: begin
          if (is_e0) begin
            state_d = S_E0;
          end else if (is_f0) begin
            state_d = S_F0;
          end else if (is_bad) begin
            kb_bad = 1'b1;
          end else if (!is_ack) begin
            emit = 1'b1;
          end
        end
        S_E0: begin
          if (is_e0) begin
            state_d = S_E0;
          end else if (is_f0) begin
            state_d = S_E0F0;
          end else if (is_bad) begin
            kb_bad  = 1'b1;
            state_d = S_IDLE;
          end else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_F0: begin
          if (is_f0) begin
            state_d = S_F0;
          end else if (is_e0) begin
            state_d = S_E0F0;
          end else if (is_bad) begin
            kb_bad  = 1'b1;
            state_d = S_IDLE;
          end else begin
            emit     = 1'b1;
            emit_rel = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_E0F0: begin
          if (is_e0 || is_f0) begin
            state_d = S_E0F0;
          end else if (is_bad) begin
            kb_bad  = 1'b1;
            state_d = S_IDLE;
          end else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_rel = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      // An abandoned prefix must not attach itself to an unrelated later byte
      if (timer_q == TMAX) begin
        state_d = S_IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else begin
      timer_d = '0;
    end
  end

  // Shift key tracking; follows every emitted event even if the FIFO drops it
  always_comb begin
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    if (emit && !emit_ext) begin
      if (byte_q == 8'h12) lshift_d = ~emit_rel;
      if (byte_q == 8'h59) rshift_d = ~emit_rel;
    end
  end

  // Shift state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      shift_held_q <= 1'b0;
    end else begin
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      shift_held_q <= lshift_d | rshift_d;
    end
  end

  assign fifo_full = (count_q == FULL_CNT);
  assign do_pop    = ev_valid & ev_ready;
  // A full FIFO can still accept an event when the head leaves in the same cycle
  assign do_push   = emit & (~fifo_full | do_pop);
  assign ovf       = emit & fifo_full & ~do_pop;

  // FIFO occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 10'h000;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= {emit_ext, emit_rel, byte_q};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // One-cycle error pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_kb_q  <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      err_kb_q  <= kb_bad;
      err_ovf_q <= ovf;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign ev_valid   = (count_q != '0);
  assign ev_code    = ev_valid ? head[7:0] : 8'h00;
  assign ev_rel     = ev_valid & head[8];
  assign ev_ext     = ev_valid & head[9];
  assign shift_held = shift_held_q;
  assign err_kb     = err_kb_q;
  assign err_ovf    = err_ovf_q;

endmodule
